// File: rtl/fipo_load_controller_if.sv
// Byte-stream and weight-memory signal bundle for fipo_load_controller.
// The master modport is the controller's view; the slave modport is the
// host/memory environment's view of the same wires.
interface fipo_load_controller_if #(
  parameter int BYTE_W = 8
);
  logic              start;
  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_clear;
  logic              mem_enable;
  logic              mem_serial_in;
  logic              mem_data_written;
  logic              mem_end_writing;
  logic              busy;
  logic              load_done;
  logic              error;
  logic [5:0]        bytes_loaded;

  modport master (
    input  start,
    input  in_data,
    input  in_valid,
    input  mem_data_written,
    input  mem_end_writing,
    output in_ready,
    output mem_clear,
    output mem_enable,
    output mem_serial_in,
    output busy,
    output load_done,
    output error,
    output bytes_loaded
  );

  modport slave (
    output start,
    output in_data,
    output in_valid,
    output mem_data_written,
    output mem_end_writing,
    input  in_ready,
    input  mem_clear,
    input  mem_enable,
    input  mem_serial_in,
    input  busy,
    input  load_done,
    input  error,
    input  bytes_loaded
  );
endinterface

// File: rtl/fipo_load_controller.sv
// Load sequencer for the 312-bit serial-in/parallel-out weight memory.
// Takes host bytes over valid/ready, shifts each byte LSB-first into the
// memory one bit per cycle, closes the frame so the memory raises its
// end-of-write pulse, and cross-checks the memory's per-bit acks before
// reporting done. Any failure wipes the memory so no partial frame survives.
module fipo_load_controller #(
  parameter int TOTAL_BITS    = 312,
  parameter int BYTE_W        = 8,
  parameter int FETCH_TIMEOUT = 255,
  parameter int END_TIMEOUT   = 4
) (
  input logic                   clk,
  input logic                   rst,
  fipo_load_controller_if.master bus
);

  localparam int IDX_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  localparam logic [8:0]       LP_TOTAL      = 9'(TOTAL_BITS);
  localparam logic [8:0]       LP_ACK_SAT    = 9'(TOTAL_BITS + 1);
  localparam logic [7:0]       LP_FETCH_LAST = 8'(FETCH_TIMEOUT - 1);
  localparam logic [7:0]       LP_END_LAST   = 8'(END_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LP_IDX_LAST   = IDX_W'(BYTE_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_SHIFT,
    S_CLOSE,
    S_WAIT_END,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [BYTE_W-1:0] r_shreg;
  logic [8:0]        r_bit_count;
  logic [8:0]        w_bit_count_inc;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [8:0]        r_ack_count;
  logic [7:0]        r_timeout;
  logic [5:0]        r_bytes_loaded;
  logic              r_err_clear;
  logic              w_handshake;
  logic              w_busy;

  assign w_bit_count_inc = r_bit_count + 9'd1;
  assign w_handshake     = (r_state == S_FETCH) && bus.in_valid;
  assign w_busy          = (r_state == S_CLEAR) || (r_state == S_FETCH) ||
                           (r_state == S_SHIFT) || (r_state == S_CLOSE) ||
                           (r_state == S_WAIT_END);

  // State register; reset drops straight back to IDLE mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: start only matters when the controller is at rest.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          w_next = S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        if (bus.in_valid) begin
          w_next = S_SHIFT;
        end else if (r_timeout == LP_FETCH_LAST) begin
          w_next = S_ERROR;
        end
      end
      S_SHIFT: begin
        if (r_bit_idx == LP_IDX_LAST) begin
          w_next = (w_bit_count_inc == LP_TOTAL) ? S_CLOSE : S_FETCH;
        end
      end
      S_CLOSE: begin
        w_next = S_WAIT_END;
      end
      S_WAIT_END: begin
        if (bus.mem_end_writing) begin
          w_next = (r_ack_count == LP_TOTAL) ? S_DONE : S_ERROR;
        end else if (r_timeout == LP_END_LAST) begin
          w_next = S_ERROR;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Byte capture, serialisation and bit/byte bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg        <= '0;
      r_bit_count    <= '0;
      r_bit_idx      <= '0;
      r_bytes_loaded <= '0;
    end else begin
      unique case (r_state)
        S_CLEAR: begin
          r_shreg        <= '0;
          r_bit_count    <= '0;
          r_bit_idx      <= '0;
          r_bytes_loaded <= '0;
        end
        S_FETCH: begin
          if (w_handshake) begin
            r_shreg        <= bus.in_data;
            r_bit_idx      <= '0;
            r_bytes_loaded <= r_bytes_loaded + 6'd1;
          end
        end
        S_SHIFT: begin
          r_shreg     <= r_shreg >> 1;
          r_bit_count <= w_bit_count_inc;
          r_bit_idx   <= r_bit_idx + IDX_W'(1);
        end
        default: begin
          r_shreg <= r_shreg;
        end
      endcase
    end
  end

  // Shared wait counter: host stall time in FETCH, end-pulse wait in WAIT_END.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timeout <= '0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_handshake) begin
            r_timeout <= '0;
          end else begin
            r_timeout <= r_timeout + 8'd1;
          end
        end
        S_WAIT_END: begin
          if (!bus.mem_end_writing) begin
            r_timeout <= r_timeout + 8'd1;
          end
        end
        default: begin
          r_timeout <= '0;
        end
      endcase
    end
  end

  // Ack tally; saturating one past the frame size keeps over-acking detectable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack_count <= '0;
    end else if (r_state == S_CLEAR) begin
      r_ack_count <= '0;
    end else if (w_busy && bus.mem_data_written && (r_ack_count != LP_ACK_SAT)) begin
      r_ack_count <= r_ack_count + 9'd1;
    end
  end

  // One-cycle memory wipe on the cycle the controller lands in ERROR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_clear <= 1'b0;
    end else begin
      r_err_clear <= (w_next == S_ERROR) && (r_state != S_ERROR);
    end
  end

  assign bus.in_ready      = (r_state == S_FETCH);
  assign bus.mem_clear     = (r_state == S_CLEAR) || r_err_clear;
  assign bus.mem_enable    = (r_state == S_SHIFT) || (r_state == S_CLOSE);
  assign bus.mem_serial_in = (r_state == S_SHIFT) && r_shreg[0];
  assign bus.busy          = w_busy;
  assign bus.load_done     = (r_state == S_DONE);
  assign bus.error         = (r_state == S_ERROR);
  assign bus.bytes_loaded  = r_bytes_loaded;

endmodule

// File: doc/fipo_load_controller.md
Name: fipo_load_controller

Overview:
- Sequences loading of the 312-bit serial-in/parallel-out weight memory from a byte-wide host stream.
- Accepts bytes over a valid/ready handshake and serialises each byte LSB-first into the memory's serial_in/enable pins, one bit per cycle.
- Closes the frame so the memory emits its end-of-write pulse, then cross-checks the memory's per-bit acknowledgements.
- Reports done or error to the network sequencer, which must not start inference until load_done is high.

Parameters:
- TOTAL_BITS, 312: bits per frame; must be a multiple of BYTE_W.
- BYTE_W, 8: input byte width.
- FETCH_TIMEOUT, 255: max consecutive FETCH cycles with in_valid low before ERROR.
- END_TIMEOUT, 4: max WAIT_END cycles without mem_end_writing before ERROR.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high. Shared with the memory.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- in_data  in  BYTE_W  host byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  high only in FETCH; a byte transfers on an edge where in_valid and in_ready are both high.
- mem_clear  out  1  one-cycle pulse that synchronously clears the memory contents and its bit counter.
- mem_enable  out  1  memory enable.
- mem_serial_in  out  1  memory serial data.
- mem_data_written  in  1  memory per-bit ack; registered one cycle after each written bit.
- mem_end_writing  in  1  memory frame-complete pulse.
- busy  out  1  high in CLEAR, FETCH, SHIFT, CLOSE and WAIT_END.
- load_done  out  1  level; high in DONE only.
- error  out  1  level; high in ERROR only.
- bytes_loaded  out  6  count of bytes accepted in the current frame, 0..39.

Behaviour:
- Reset values: every output 0; state IDLE; internal counters 0.
- States and transitions:
  - IDLE/DONE/ERROR: start -> CLEAR.
  - CLEAR: one cycle, mem_clear=1; byte, bit, ack and timeout counters zeroed -> FETCH.
  - FETCH: in_ready=1. On handshake: latch in_data into the shift register, bytes_loaded+1 -> SHIFT. If the timeout counter reaches FETCH_TIMEOUT -> ERROR.
  - SHIFT: mem_enable=1 and mem_serial_in=shreg[0] for exactly BYTE_W cycles; shift right each edge; bit_count+1 each edge. After the last bit: bit_count==TOTAL_BITS -> CLOSE, else -> FETCH.
  - CLOSE: one cycle with mem_enable=1 and mem_serial_in=0, so the memory sees its counter at TOTAL_BITS and raises end_writing -> WAIT_END.
  - WAIT_END: on mem_end_writing=1, go DONE if ack_count==TOTAL_BITS, else ERROR. After END_TIMEOUT cycles without the pulse -> ERROR.
- mem_enable and mem_serial_in are decoded from the registered state and shift register; no combinational path from inputs.
- ack_count increments on every sampled mem_data_written while busy. It saturates at TOTAL_BITS+1, so extra acks produce ERROR.
- The FETCH timeout counter resets on each handshake.
- Entering ERROR pulses mem_clear for one cycle so a partial frame is never left in the memory.
- Latency: with in_valid held high, start sampled at edge E0 gives load_done high after edge E0+354:
  - 1 CLEAR cycle
  - 39 x (1 FETCH + 8 SHIFT) cycles
  - 1 CLOSE cycle
  - 1 WAIT_END cycle
- start while busy is ignored, with no effect on state or outputs.
- in_valid outside FETCH is ignored and no byte is consumed.
- start in DONE or ERROR clears load_done/error on the next edge, since state moves to CLEAR.
- rst mid-frame forces IDLE immediately. The memory shares rst, so the partial frame is discarded.
- Counter widths: bit_count 9 bits, ack_count 9 bits, timeout 8 bits.

Test Plan:
- Full load, in_valid always high, 39 bytes 0x00..0x26 -> load_done rises at E0+354; parallel_out byte k equals k (bit 8k+i = byte k bit i); error=0; bytes_loaded=39.
- Stalled host: in_valid low 20 cycles between bytes 10 and 11 -> in_ready stays high for those cycles; no mem_enable; final memory image identical to the full-load case; done 20 cycles later.
- Timeout: send 5 bytes, then hold in_valid low -> ERROR after 255 FETCH cycles; error=1; one mem_clear pulse; memory reads all zeros.
- Ack fault: bench suppresses one mem_data_written pulse -> ERROR on the mem_end_writing edge; load_done stays 0.
- start during SHIFT, then rst asserted asynchronously mid-byte 20 -> start ignored; on rst all outputs 0 and state IDLE; a new start completes normally in 354 cycles.
- Reload from DONE with all bytes 0xFF -> load_done drops on the start edge, then rises after 354 edges; memory reads all ones.
